// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl_if
// Brief   : Decode/execute/memory status inputs and pipeline control outputs
//           of the central stall/flush scheduler.
// Revision: 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if;
  // Decode-stage operand information
  logic        dec_valid;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic        dec_uses_rs1;
  logic        dec_uses_rs2;
  logic        dec_is_load;
  logic [4:0]  dec_rd;
  logic        dec_read_bubble;
  // Execute / memory events
  logic        ex_redirect;
  logic        dcache_stall;
  logic        load_done;
  logic [4:0]  load_rd;
  // Pipeline controls and status
  logic        freeze;
  logic        stall_fd;
  logic        bubble_x;
  logic        flush;
  logic        issue;
  logic [31:0] pending;
  logic [2:0]  load_cnt;
  logic [1:0]  state;
  logic        err;

  // Pipeline side: drives the events, observes the controls
  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
           dec_is_load, dec_rd, dec_read_bubble,
           ex_redirect, dcache_stall, load_done, load_rd,
    input  freeze, stall_fd, bubble_x, flush, issue,
           pending, load_cnt, state, err
  );

  // Scheduler side
  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
           dec_is_load, dec_rd, dec_read_bubble,
           ex_redirect, dcache_stall, load_done, load_rd,
    output freeze, stall_fd, bubble_x, flush, issue,
           pending, load_cnt, state, err
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Stall/flush scheduler for the three-stage pipeline. Tracks loads
//           in flight in a register scoreboard and issues freeze, stall,
//           bubble and flush controls for fetch, decode and execute.
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int MAX_LOADS    = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [2:0] c_MAX_LOADS    = 3'(MAX_LOADS);
  localparam logic [2:0] c_FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam bit         c_USE_FLUSH    = (FLUSH_CYCLES > 1);

  state_t      r_state;
  logic [2:0]  r_flush_cnt;
  logic [31:0] r_pending;
  logic [2:0]  r_load_cnt;
  logic        r_err;

  logic        w_hazard;
  logic        w_full;
  logic        w_run_rules;
  logic        w_freeze;
  logic        w_stall_fd;
  logic        w_bubble_x;
  logic        w_flush;
  logic        w_issue;
  logic        w_load_issue;
  logic        w_load_retire;
  logic [31:0] w_pending_nxt;

  // Operand hazard against loads in flight; x0 is never a real dependency
  assign w_hazard = bus.dec_valid &
                    ((bus.dec_uses_rs1 & (bus.dec_rs1 != 5'd0) & r_pending[bus.dec_rs1]) |
                     (bus.dec_uses_rs2 & (bus.dec_rs2 != 5'd0) & r_pending[bus.dec_rs2]) |
                     bus.dec_read_bubble);

  assign w_full = bus.dec_valid & bus.dec_is_load & (r_load_cnt == c_MAX_LOADS);

  // MEM_WAIT with the miss resolved behaves exactly like RUN this cycle, so a
  // redirect held across the freeze is acted on at exit
  assign w_run_rules = (r_state == RUN) | ((r_state == MEM_WAIT) & ~bus.dcache_stall);

  // Combinational pipeline controls, forced quiet while reset is asserted
  always_comb begin
    w_freeze   = 1'b0;
    w_stall_fd = 1'b0;
    w_bubble_x = 1'b0;
    w_flush    = 1'b0;
    w_issue    = 1'b0;
    if (reset_n) begin
      if (w_run_rules) begin
        if (bus.dcache_stall) begin
          w_freeze   = 1'b1;
          w_stall_fd = 1'b1;
        end else if (bus.ex_redirect) begin
          w_flush    = 1'b1;
          w_bubble_x = 1'b1;
        end else if (w_hazard | w_full) begin
          w_stall_fd = 1'b1;
          w_bubble_x = 1'b1;
        end else begin
          w_issue    = bus.dec_valid;
        end
      end else if (r_state == MEM_WAIT) begin
        w_freeze   = 1'b1;
        w_stall_fd = 1'b1;
      end else if (r_state == FLUSH) begin
        // Hazards and redirects are ignored while draining the redirect
        w_bubble_x = 1'b1;
        w_freeze   = bus.dcache_stall;
      end
    end
  end

  assign w_load_issue  = w_issue & bus.dec_is_load;
  assign w_load_retire = bus.load_done & (r_load_cnt != 3'd0);

  // Scoreboard next value: clear on writeback, then set on load issue
  always_comb begin
    w_pending_nxt = r_pending;
    if (bus.load_done) begin
      w_pending_nxt[bus.load_rd] = 1'b0;
    end
    if (w_load_issue & (bus.dec_rd != 5'd0)) begin
      w_pending_nxt[bus.dec_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  // Scheduler state, flush counter, scoreboard, load count and error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RUN;
      r_flush_cnt <= 3'd0;
      r_pending   <= 32'd0;
      r_load_cnt  <= 3'd0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        RUN, MEM_WAIT: begin
          if (bus.dcache_stall) begin
            r_state <= MEM_WAIT;
          end else if (bus.ex_redirect && c_USE_FLUSH) begin
            r_state     <= FLUSH;
            r_flush_cnt <= c_FLUSH_RELOAD;
          end else begin
            r_state <= RUN;
          end
        end
        FLUSH: begin
          // A miss during the drain only holds the counter
          if (!bus.dcache_stall) begin
            if (r_flush_cnt <= 3'd1) begin
              r_state     <= RUN;
              r_flush_cnt <= 3'd0;
            end else begin
              r_flush_cnt <= r_flush_cnt - 3'd1;
            end
          end
        end
        default: begin
          r_state     <= RUN;
          r_flush_cnt <= 3'd0;
        end
      endcase

      r_pending <= w_pending_nxt;

      case ({w_load_issue, w_load_retire})
        2'b10:   r_load_cnt <= r_load_cnt + 3'd1;
        2'b01:   r_load_cnt <= r_load_cnt - 3'd1;
        default: r_load_cnt <= r_load_cnt;
      endcase

      if (bus.load_done && (r_load_cnt == 3'd0)) begin
        r_err <= 1'b1;
      end
    end
  end

  // The full check must make a load issue at the limit impossible
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(w_load_issue && (r_load_cnt == c_MAX_LOADS)));
    end
  end

  assign bus.freeze   = w_freeze;
  assign bus.stall_fd = w_stall_fd;
  assign bus.bubble_x = w_bubble_x;
  assign bus.flush    = w_flush;
  assign bus.issue    = w_issue;
  assign bus.pending  = r_pending;
  assign bus.load_cnt = r_load_cnt;
  assign bus.state    = r_state;
  assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Directed self-checking bench for pipeline_hazard_ctrl
//           (MAX_LOADS=2, FLUSH_CYCLES=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  pipeline_hazard_ctrl_if bif ();

  pipeline_hazard_ctrl #(
    .MAX_LOADS    (2),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif.slave)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bif.dec_valid       = 1'b0;
    bif.dec_rs1         = 5'd0;
    bif.dec_rs2         = 5'd0;
    bif.dec_uses_rs1    = 1'b0;
    bif.dec_uses_rs2    = 1'b0;
    bif.dec_is_load     = 1'b0;
    bif.dec_rd          = 5'd0;
    bif.dec_read_bubble = 1'b0;
    bif.ex_redirect     = 1'b0;
    bif.dcache_stall    = 1'b0;
    bif.load_done       = 1'b0;
    bif.load_rd         = 5'd0;
  endtask

  task automatic load(input logic [4:0] rd);
    idle();
    bif.dec_valid   = 1'b1;
    bif.dec_is_load = 1'b1;
    bif.dec_rd      = rd;
  endtask

  task automatic alu(input logic [4:0] rs1, input logic [4:0] rd);
    idle();
    bif.dec_valid    = 1'b1;
    bif.dec_rs1      = rs1;
    bif.dec_uses_rs1 = 1'b1;
    bif.dec_rd       = rd;
  endtask

  // Controls packed as {freeze, stall_fd, bubble_x, flush, issue}
  function automatic logic [31:0] ctl();
    return {27'd0, bif.freeze, bif.stall_fd, bif.bubble_x, bif.flush, bif.issue};
  endfunction

  // Advance to just after the next active edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    n_checks = 0;
    n_fail = 0;

    // Reset with busy inputs: every control must stay quiet
    idle();
    reset_n = 1'b0;
    bif.dec_valid    = 1'b1;
    bif.ex_redirect  = 1'b1;
    bif.dcache_stall = 1'b1;
    #2;
    chk("rst_ctl", ctl(), 32'h00);
    chk("rst_state", 32'(bif.state), 32'd0);
    chk("rst_pending", bif.pending, 32'd0);
    chk("rst_cnt", 32'(bif.load_cnt), 32'd0);
    chk("rst_err", 32'(bif.err), 32'd0);
    #10;
    idle();
    reset_n = 1'b1;

    // Load-use: load x5, then consumer of x5 waits for writeback
    load(5'd5);
    #2 chk("lu_load_ctl", ctl(), 32'h01);
    cyc();
    alu(5'd5, 5'd6);
    #2 chk("lu_pending", bif.pending, 32'h20);
    chk("lu_cnt", 32'(bif.load_cnt), 32'd1);
    chk("lu_stall_ctl", ctl(), 32'h0C);
    cyc();
    alu(5'd5, 5'd6);
    bif.load_done = 1'b1;
    bif.load_rd   = 5'd5;
    #2 chk("lu_wb_ctl", ctl(), 32'h0C);
    cyc();
    alu(5'd5, 5'd6);
    #2 chk("lu_clr_pending", bif.pending, 32'h0);
    chk("lu_clr_cnt", 32'(bif.load_cnt), 32'd0);
    chk("lu_issue_ctl", ctl(), 32'h01);
    cyc();

    // x0 destination: counted but never marked pending
    load(5'd0);
    #2 chk("x0_load_ctl", ctl(), 32'h01);
    cyc();
    alu(5'd0, 5'd7);
    bif.load_done = 1'b1;
    bif.load_rd   = 5'd0;
    #2 chk("x0_pending", bif.pending, 32'h0);
    chk("x0_cnt", 32'(bif.load_cnt), 32'd1);
    chk("x0_use_ctl", ctl(), 32'h01);
    cyc();

    // Outstanding-load limit
    load(5'd3);
    #2 chk("lim_cnt0", 32'(bif.load_cnt), 32'd0);
    chk("lim_l3_ctl", ctl(), 32'h01);
    cyc();
    load(5'd4);
    #2 chk("lim_cnt1", 32'(bif.load_cnt), 32'd1);
    chk("lim_l4_ctl", ctl(), 32'h01);
    cyc();
    load(5'd7);
    #2 chk("lim_cnt2", 32'(bif.load_cnt), 32'd2);
    chk("lim_pending", bif.pending, 32'h18);
    chk("lim_full_ctl", ctl(), 32'h0C);
    cyc();
    load(5'd7);
    bif.load_done = 1'b1;
    bif.load_rd   = 5'd3;
    #2 chk("lim_wb_ctl", ctl(), 32'h0C);
    cyc();
    load(5'd7);
    #2 chk("lim_after_cnt", 32'(bif.load_cnt), 32'd1);
    chk("lim_after_pending", bif.pending, 32'h10);
    chk("lim_third_ctl", ctl(), 32'h01);
    cyc();
    idle();
    bif.load_done = 1'b1;
    bif.load_rd   = 5'd4;
    #2 chk("lim_both_pending", bif.pending, 32'h90);
    chk("lim_both_cnt", 32'(bif.load_cnt), 32'd2);
    cyc();
    idle();
    bif.load_done = 1'b1;
    bif.load_rd   = 5'd7;
    cyc();
    idle();
    #2 chk("drain_cnt", 32'(bif.load_cnt), 32'd0);
    chk("drain_pending", bif.pending, 32'h0);

    // Redirect: two bubbles, then issue resumes
    alu(5'd1, 5'd2);
    bif.ex_redirect = 1'b1;
    #2 chk("rd_c0_ctl", ctl(), 32'h06);
    chk("rd_c0_state", 32'(bif.state), 32'd0);
    cyc();
    alu(5'd1, 5'd2);
    #2 chk("rd_c1_state", 32'(bif.state), 32'd2);
    chk("rd_c1_ctl", ctl(), 32'h04);
    cyc();
    alu(5'd1, 5'd2);
    #2 chk("rd_c2_state", 32'(bif.state), 32'd0);
    chk("rd_c2_ctl", ctl(), 32'h01);
    cyc();

    // Miss overlapping a held redirect, with a writeback during the miss
    load(5'd9);
    #2 chk("mo_load_ctl", ctl(), 32'h01);
    cyc();
    for (int i = 0; i < 4; i++) begin
      idle();
      bif.dcache_stall = 1'b1;
      bif.ex_redirect  = 1'b1;
      if (i == 2) begin
        bif.load_done = 1'b1;
        bif.load_rd   = 5'd9;
      end
      #2 chk($sformatf("mo_freeze_ctl%0d", i), ctl(), 32'h18);
      chk($sformatf("mo_state%0d", i), 32'(bif.state), (i == 0) ? 32'd0 : 32'd1);
      cyc();
    end
    idle();
    bif.ex_redirect = 1'b1;
    #2 chk("mo_exit_state", 32'(bif.state), 32'd1);
    chk("mo_exit_ctl", ctl(), 32'h06);
    chk("mo_pending", bif.pending, 32'h0);
    chk("mo_cnt", 32'(bif.load_cnt), 32'd0);
    cyc();
    // Miss during the drain: freeze, counter holds
    idle();
    bif.dcache_stall = 1'b1;
    #2 chk("fl_frz_state", 32'(bif.state), 32'd2);
    chk("fl_frz_ctl", ctl(), 32'h14);
    cyc();
    alu(5'd1, 5'd2);
    #2 chk("fl_hold_state", 32'(bif.state), 32'd2);
    chk("fl_hold_ctl", ctl(), 32'h04);
    cyc();
    alu(5'd1, 5'd2);
    #2 chk("fl_done_state", 32'(bif.state), 32'd0);
    chk("fl_done_ctl", ctl(), 32'h01);
    cyc();

    // Protocol error: writeback with nothing outstanding
    idle();
    bif.load_done = 1'b1;
    bif.load_rd   = 5'd1;
    #2 chk("err_pre", 32'(bif.err), 32'd0);
    cyc();
    load(5'd12);
    #2 chk("err_set", 32'(bif.err), 32'd1);
    chk("err_cnt", 32'(bif.load_cnt), 32'd0);
    cyc();
    alu(5'd1, 5'd2);
    bif.ex_redirect = 1'b1;
    #2 chk("pre_rst_pending", bif.pending, 32'h1000);
    cyc();

    // Asynchronous reset while draining a redirect
    alu(5'd12, 5'd2);
    bif.ex_redirect = 1'b1;
    #1 chk("pre_rst_state", 32'(bif.state), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("arst_state", 32'(bif.state), 32'd0);
    chk("arst_pending", bif.pending, 32'h0);
    chk("arst_err", 32'(bif.err), 32'd0);
    chk("arst_cnt", 32'(bif.load_cnt), 32'd0);
    chk("arst_ctl", ctl(), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
